// File: rtl/lc3b_mem_ctrl_pkg.sv
// Shared types and constants for the LC-3b MAR/MDR memory controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package lc3b_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  localparam int MEM_AW_DEFAULT = 8;
  localparam int LATENCY_MAX    = 15;
  localparam int CNT_W          = $clog2(LATENCY_MAX + 1);

endpackage

// File: rtl/lc3b_mem_ctrl_if.sv
// Datapath-side request/response bundle of the memory controller.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready on requests, resp_valid/resp_ready on responses.
interface lc3b_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;

  // Datapath side: issues requests, consumes responses.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Controller side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lc3b_mem_ctrl_load_align.sv
// Formats raw memory read data into the load result (word, LDB sign/zero extend).
// Latency: purely combinational.
// Backpressure: none.
module lc3b_load_align
  import lc3b_mem_pkg::*;
(
  input  logic        size,
  input  logic        sign_ext,
  input  logic [15:0] mem_rdata,
  output logic [15:0] load_val
);

  // Words pass through; bytes take the low lane and extend per sign_ext.
  always_comb begin
    load_val = mem_rdata;
    if (size == SIZE_BYTE) begin
      load_val = sign_ext ? {{8{mem_rdata[7]}}, mem_rdata[7:0]} : {8'd0, mem_rdata[7:0]};
    end
  end

endmodule

// File: rtl/lc3b_mem_ctrl.sv
// MAR/MDR controller between LC-3b datapath and unified memory; optional LC3B_MEM_ALIGN_CHECK_EN fault check.
// Latency: response valid LATENCY cycles after acceptance (next cycle for a faulting request).
// Backpressure: one transaction in flight; req_ready low until the response is taken.
module lc3b_mem_ctrl
  import lc3b_mem_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int MEM_AW  = MEM_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  lc3b_mem_ctrl_if.slave    dp,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_size,
  output logic              mem_write_n,
  input  logic [15:0]       mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [MEM_AW-1:0]  mar_q;
  logic [15:0]        mdr_q;
  logic [15:0]        rdata_q;
  logic               size_q, write_q, signed_q, err_q;
  logic               accept, fault, last_access;
  logic [15:0]        load_val;

  assign accept      = (state_q == IDLE) & dp.req_valid;
  assign last_access = (state_q == ACCESS) & (cnt_q == '0);

`ifdef LC3B_MEM_ALIGN_CHECK_EN
  // Unaligned words and addresses beyond the memory window fault at acceptance.
  assign fault = (dp.req_size & dp.req_addr[0]) | (|dp.req_addr[15:MEM_AW]);
`else
  // Address is simply truncated; upper bits are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^dp.req_addr[15:MEM_AW];
  assign fault = 1'b0;
`endif

  lc3b_load_align u_load_align (
    .size      (size_q),
    .sign_ext  (signed_q),
    .mem_rdata (mem_rdata),
    .load_val  (load_val)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: faults bypass ACCESS; RESP waits for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = fault ? RESP : ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = RESP;
      RESP:    if (dp.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: strobe only in the last ACCESS cycle of a store, never during reset.
  always_comb begin
    dp.req_ready  = (state_q == IDLE);
    dp.resp_valid = (state_q == RESP);
    mem_write_n   = ~(last_access & write_q & ~rst);
  end

  // Datapath registers: MAR/MDR latch at accept, response captured at last ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      size_q   <= SIZE_BYTE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      err_q <= fault;
      if (fault) begin
        rdata_q <= '0;
      end else begin
        mar_q    <= dp.req_addr[MEM_AW-1:0];
        mdr_q    <= dp.req_wdata;
        size_q   <= dp.req_size;
        write_q  <= dp.req_write;
        signed_q <= dp.req_signed;
        cnt_q    <= CNT_INIT;
      end
    end else if (state_q == ACCESS) begin
      if (cnt_q == '0) rdata_q <= write_q ? 16'd0 : load_val;
      else             cnt_q   <= cnt_q - 1'b1;
    end
  end

  assign mem_addr      = mar_q;
  assign mem_wdata     = mdr_q;
  assign mem_size      = size_q;
  assign dp.resp_rdata = rdata_q;
  assign dp.resp_err   = err_q;

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// Bench for lc3b_mem_ctrl: behavioural memory, transaction-level reference model,
// per-cycle compare process, directed literal checks and randomized traffic.
module tb_lc3b_mem_ctrl;
  import lc3b_mem_pkg::*;

  localparam int LAT = 2;
  localparam int AW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lc3b_mem_ctrl_if dp();
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata, mem_rdata;
  logic          mem_size, mem_write_n;

  lc3b_mem_ctrl #(.LATENCY(LAT), .MEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .dp(dp),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_write_n(mem_write_n), .mem_rdata(mem_rdata)
  );

  // Behavioural byte memory (little-endian words) and the model's shadow copy.
  logic [7:0] mem [256];
  logic [7:0] sh  [256];

  assign mem_rdata = mem_size ? {mem[mem_addr + 8'd1], mem[mem_addr]} : {8'd0, mem[mem_addr]};

  always @(posedge clk) begin
    if (mem_write_n === 1'b0) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (mem_size) mem[mem_addr + 8'd1] <= mem_wdata[15:8];
    end
  end

  int strobes = 0;
  always @(negedge clk) if (mem_write_n === 1'b0) strobes++;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_fault(input logic sz, input logic [15:0] a);
`ifdef LC3B_MEM_ALIGN_CHECK_EN
    return (sz && a[0]) || (a[15:8] != 8'd0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- transaction-level reference model ----------------
  bit         busy = 0;
  int         k = 0;
  int         lat_eff = LAT;
  bit         t_write, t_size, t_signed, t_fault;
  logic [7:0] t_addr;
  logic [15:0] t_wdata;
  logic [7:0]  m_mar = 8'd0;
  logic [15:0] m_mdr = 16'd0;
  logic [15:0] m_rdata = 16'd0;
  logic        m_size = 1'b0;
  logic        m_err = 1'b0;
  bit          en = 0;

  always @(posedge clk) begin
    logic [7:0] lo, hi;
    if (rst) begin
      busy = 0; k = 0;
      m_mar = 8'd0; m_mdr = 16'd0; m_size = 1'b0; m_rdata = 16'd0; m_err = 1'b0;
    end else if (!busy) begin
      if (dp.req_valid) begin
        busy = 1; k = 0;
        t_write = dp.req_write; t_size = dp.req_size; t_signed = dp.req_signed;
        t_addr = dp.req_addr[7:0]; t_wdata = dp.req_wdata;
        t_fault = is_fault(dp.req_size, dp.req_addr);
        if (t_fault) begin
          lat_eff = 0; m_rdata = 16'd0; m_err = 1'b1;
        end else begin
          lat_eff = LAT; m_mar = t_addr; m_mdr = t_wdata; m_size = t_size;
        end
      end
    end else if (k >= lat_eff) begin
      if (dp.resp_ready) busy = 0;
    end else begin
      if (k == lat_eff - 1) begin
        lo = sh[t_addr];
        hi = sh[t_addr + 8'd1];
        m_err = 1'b0;
        if (t_write) begin
          sh[t_addr] = t_wdata[7:0];
          if (t_size) sh[t_addr + 8'd1] = t_wdata[15:8];
          m_rdata = 16'd0;
        end else if (t_size) m_rdata = {hi, lo};
        else if (t_signed)   m_rdata = 16'($signed(lo));
        else                 m_rdata = 16'(lo);
      end
      k++;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    #2;
    if (en) begin
      chk("req_ready",   dp.req_ready,  !busy);
      chk("resp_valid",  dp.resp_valid, busy && k >= lat_eff);
      chk("mem_write_n", mem_write_n,
          !(busy && !rst && t_write && !t_fault && k == lat_eff - 1));
      chk("mem_addr",    mem_addr,      m_mar);
      chk("mem_wdata",   mem_wdata,     m_mdr);
      chk("resp_rdata",  dp.resp_rdata, m_rdata);
      if (busy && k >= lat_eff) chk("resp_err", dp.resp_err, m_err);
      if (busy && k < lat_eff)  chk("mem_size", mem_size, m_size);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_txn(input bit w, input bit sz, input bit sg, input logic [15:0] a,
                        input logic [15:0] wd, input int hold,
                        output logic [15:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    dp.req_valid = 1'b1; dp.req_write = w; dp.req_size = sz; dp.req_signed = sg;
    dp.req_addr = a; dp.req_wdata = wd;
    n = 0;
    while (!dp.req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    dp.req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!dp.resp_valid && lat < 40) begin lat++; @(negedge clk); end
    if (lat >= 40) chk("resp_timeout", 1, 0);
    rd = dp.resp_rdata; er = dp.resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", dp.resp_valid, 1);
      chk("hold_req_ready", dp.req_ready, 0);
      chk("hold_rdata", dp.resp_rdata, rd);
    end
    dp.resp_ready = 1'b1;
    @(posedge clk); #1;
    dp.resp_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_resp", dp.req_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd, a;
    logic        er;
    int          lat, s0, diff;
    bit          w, sz, sg;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h28] = 8'h26; mem[8'h29] = 8'h00;
    mem[8'h10] = 8'h34; mem[8'h11] = 8'h0C;
    mem[8'h2A] = 8'hE8; mem[8'h2B] = 8'h03;
    for (int i = 0; i < 256; i++) sh[i] = mem[i];

    dp.req_valid = 0; dp.req_write = 0; dp.req_size = 0; dp.req_signed = 0;
    dp.req_addr = 0; dp.req_wdata = 0; dp.resp_ready = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    en = 1;
    @(negedge clk); #1;
    chk("rst_req_ready",  dp.req_ready, 1);
    chk("rst_resp_valid", dp.resp_valid, 0);
    chk("rst_write_n",    mem_write_n, 1);
    chk("rst_mem_addr",   mem_addr, 0);
    chk("rst_rdata",      dp.resp_rdata, 0);
    chk("rst_err",        dp.resp_err, 0);

    do_txn(0, 1, 0, 16'h0028, 16'h0, 0, rd, er, lat);
    chk("lat_word", lat, LAT);
    chk("ld_w_0028", rd, 16'h0026);
    chk("err_0028", er, 0);
    do_txn(0, 0, 1, 16'h0010, 16'h0, 0, rd, er, lat);
    chk("ldb_s_0010", rd, 16'h0034);
    do_txn(0, 0, 1, 16'h0011, 16'h0, 1, rd, er, lat);
    chk("ldb_s_0011", rd, 16'h000C);
    do_txn(0, 1, 0, 16'h002A, 16'h0, 0, rd, er, lat);
    chk("ld_w_002A", rd, 16'h03E8);

    s0 = strobes;
    do_txn(1, 0, 0, 16'h00F0, 16'hAB80, 0, rd, er, lat);
    chk("stb_one_strobe", strobes - s0, 1);
    chk("st_rdata_zero", rd, 16'h0000);
    do_txn(0, 0, 1, 16'h00F0, 16'h0, 0, rd, er, lat);
    chk("ldb_s_00F0", rd, 16'hFF80);
    do_txn(0, 0, 0, 16'h00F0, 16'h0, 0, rd, er, lat);
    chk("ldb_u_00F0", rd, 16'h0080);
    chk("mem_F1_kept", mem[8'hF1], 8'h54);

    do_txn(1, 1, 0, 16'h00F2, 16'h1234, 0, rd, er, lat);
    do_txn(0, 1, 0, 16'h00F2, 16'h0, 3, rd, er, lat);
    chk("ld_w_00F2_held", rd, 16'h1234);

    // Reset during the final ACCESS cycle of a store must cancel the write.
    s0 = strobes;
    @(negedge clk);
    dp.req_valid = 1; dp.req_write = 1; dp.req_size = 0; dp.req_signed = 0;
    dp.req_addr = 16'h0040; dp.req_wdata = 16'h0077;
    @(posedge clk); #1;
    dp.req_valid = 0;
    repeat (LAT) @(negedge clk);
    rst = 1;
    #1 chk("abort_write_n", mem_write_n, 1);
    @(posedge clk); #1;
    rst = 0;
    chk("abort_no_strobe", strobes - s0, 0);
    chk("abort_mem_40", mem[8'h40], 8'hE5);
    chk("abort_req_ready", dp.req_ready, 1);
    chk("abort_resp_valid", dp.resp_valid, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_rdata", dp.resp_rdata, 0);

`ifdef LC3B_MEM_ALIGN_CHECK_EN
    s0 = strobes;
    do_txn(0, 1, 0, 16'h0029, 16'h0, 0, rd, er, lat);
    chk("flt_w_lat", lat, 0);
    chk("flt_w_err", er, 1);
    chk("flt_w_rdata", rd, 0);
    do_txn(0, 0, 0, 16'h0100, 16'h0, 1, rd, er, lat);
    chk("flt_hi_lat", lat, 0);
    chk("flt_hi_err", er, 1);
    chk("flt_hi_rdata", rd, 0);
    do_txn(1, 1, 0, 16'h0031, 16'hBEEF, 0, rd, er, lat);
    chk("flt_st_no_strobe", strobes - s0, 0);
`else
    do_txn(0, 1, 0, 16'h0100, 16'h0, 0, rd, er, lat);
    chk("wrap_0100_word", rd, 16'hA4A5);
    chk("wrap_0100_err", er, 0);
    do_txn(0, 0, 0, 16'h0100, 16'h0, 0, rd, er, lat);
    chk("wrap_0100_byte", rd, 16'h00A5);
`endif

    for (int t = 0; t < 80; t++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      a  = {8'd0, 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 7) == 0) a[15:8] = 8'($urandom_range(1, 255));
      do_txn(w, sz, sg, a, 16'($urandom), $urandom_range(0, 3), rd, er, lat);
      chk("rand_latency", lat, is_fault(sz, a) ? 0 : LAT);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    diff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== sh[i]) diff++;
    chk("mem_vs_model", diff, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
